adder_16bit_sync: RTL and testbench
===================================

Name: adder_16bit_sync

Overview:
- Registered 16-bit two's-complement/unsigned adder with carry-in, carry-out and signed-overflow flag.
- Sits in the datapath as a single-cycle arithmetic stage.
- Internally built as four 4-bit carry-lookahead groups with group generate/propagate combined into a second-level lookahead; not a behavioural "+".
- Results are registered with a valid qualifier.

Parameters:
- WIDTH, 16, operand/sum width. Fixed at 16; other values are unsupported and need not elaborate.
- GROUP, 4, carry-lookahead group size in bits. Fixed at 4.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high, sampled on clk rising edge.
- in_valid  input  1  operands valid this cycle.
- a  input  16  operand A.
- b  input  16  operand B.
- cin  input  1  carry into bit 0.
- sum  output  16  registered (a + b + cin) mod 2^16.
- cout  output  1  registered carry out of bit 15.
- overflow  output  1  registered signed overflow.
- out_valid  output  1  registered copy of in_valid.

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1: sum=16'h0000, cout=0, overflow=0, out_valid=0. Reset has priority over in_valid.
- Reset mid-operation: any result in flight is discarded. out_valid is 0 on the cycle after the reset edge.
- Latency is exactly 1 cycle. Inputs sampled on edge N with in_valid=1 appear on the outputs after edge N, with out_valid=1. Full throughput: a new operation every cycle, no backpressure.
- in_valid=0 at an edge: out_valid goes 0, and sum/cout/overflow hold their previous values.
- Arithmetic: the 17-bit result {cout,sum} = a + b + cin, computed unsigned.
- overflow = (a[15] == b[15]) && (sum[15] != a[15]). This is a signed two's-complement overflow and is independent of cout.
- Carry structure:
  - Per bit: g = a & b, p = a ^ b.
  - Group carries: c4, c8, c12, c16 come from group G/P terms and cin via the lookahead.
  - Sum bit: s_i = p_i ^ c_i.
- Wrap-around: results modulo 2^16, no saturation (unless the optional feature is enabled).
- Outputs are purely registered; there is no combinational path from inputs to outputs.
- X on inputs while in_valid=0 must not corrupt the held outputs.

Optional Feature:
- Macro ADDER_16BIT_SAT_EN.
- When defined: on a signed overflow, sum is clamped. If a[15]=0 (positive overflow), sum=16'h7FFF. If a[15]=1 (negative overflow), sum=16'h8000.
- With the macro defined, overflow and cout are still reported exactly as in the unsaturated case.
- When undefined: plain wrap-around sum, and the saturation logic is absent from the netlist.

Test Plan:
- Basic add: rst 2 cycles, then a=0001, b=0001, cin=0 -> one cycle later sum=0002, cout=0, overflow=0, out_valid=1.
- Carry chain: a=FFFF, b=0001, cin=0 -> sum=0000, cout=1, overflow=0. Also a=000F, b=0000, cin=1 -> sum=0010, cout=0, overflow=0.
- Signed overflow: a=7FFF, b=0001, cin=0 -> sum=8000, cout=0, overflow=1 (SAT_EN: sum=7FFF). Also a=8000, b=8000 -> sum=0000, cout=1, overflow=1 (SAT_EN: sum=8000).
- Boundaries: 0000+0000, cin=0 -> 0000/0/0. FFFF+FFFF, cin=0 -> FFFE/1/0. 0000+0000, cin=1 -> 0001/0/0.
- Control: in_valid=0 for 2 cycles -> out_valid=0 and outputs hold. Assert rst during back-to-back valid traffic -> all outputs zero next cycle and stream resumes one cycle after rst falls.
- Random: 1000 random a/b/cin with in_valid=1 each cycle -> every output matches the reference {cout,sum} = a+b+cin and the overflow formula, delayed by exactly one cycle.

Source files
------------

// File: rtl/adder_16bit_sync_if.sv
// adder_16bit_sync_if: operand/result bundle for adder_16bit_sync
interface adder_16bit_sync_if;
   logic        in_valid;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic [15:0] sum;
   logic        cout;
   logic        overflow;
   logic        out_valid;
   modport master (output in_valid, a, b, cin, input sum, cout, overflow, out_valid);
   modport slave (input in_valid, a, b, cin, output sum, cout, overflow, out_valid);
endinterface

// File: rtl/adder_16bit_sync.sv
// adder_16bit_sync: registered 16-bit adder built from 4-bit CLA groups and a second-level lookahead.
// Define ADDER_16BIT_SAT_EN to clamp the sum on signed overflow.
module adder_16bit_sync #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input logic clk,
   input logic rst,
   adder_16bit_sync_if.slave bus
);
   logic [WIDTH-1:0] g, p, c, raw, sum_d, sum_q;
   logic [3:0] gg, gp;
   logic [4:0] gc;
   logic ovf_d, cout_q, ovf_q, valid_q;
   assign g = bus.a & bus.b;
   assign p = bus.a ^ bus.b;
   for (genvar k = 0; k < WIDTH / GROUP; k++) begin : grp
      logic [3:0] gi, pi;
      assign gi = g[GROUP*k +: GROUP];
      assign pi = p[GROUP*k +: GROUP];
      assign gg[k] = gi[3] | pi[3] & gi[2] | pi[3] & pi[2] & gi[1] | pi[3] & pi[2] & pi[1] & gi[0];
      assign gp[k] = &pi;
      assign c[GROUP*k]     = gc[k];
      assign c[GROUP*k + 1] = gi[0] | pi[0] & gc[k];
      assign c[GROUP*k + 2] = gi[1] | pi[1] & gi[0] | pi[1] & pi[0] & gc[k];
      assign c[GROUP*k + 3] = gi[2] | pi[2] & gi[1] | pi[2] & pi[1] & gi[0] | pi[2] & pi[1] & pi[0] & gc[k];
   end
   // second-level lookahead: every group carry depends only on group G/P and cin
   assign gc[0] = bus.cin;
   assign gc[1] = gg[0] | gp[0] & bus.cin;
   assign gc[2] = gg[1] | gp[1] & gg[0] | gp[1] & gp[0] & bus.cin;
   assign gc[3] = gg[2] | gp[2] & gg[1] | gp[2] & gp[1] & gg[0] | gp[2] & gp[1] & gp[0] & bus.cin;
   assign gc[4] = gg[3] | gp[3] & gg[2] | gp[3] & gp[2] & gg[1] | gp[3] & gp[2] & gp[1] & gg[0]
                | gp[3] & gp[2] & gp[1] & gp[0] & bus.cin;
   assign raw = p ^ c;
   assign ovf_d = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (raw[WIDTH-1] != bus.a[WIDTH-1]);
`ifdef ADDER_16BIT_SAT_EN
   assign sum_d = ovf_d ? (bus.a[WIDTH-1] ? 16'h8000 : 16'h7FFF) : raw;
`else
   assign sum_d = raw;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            sum_q  <= sum_d;
            cout_q <= gc[4];
            ovf_q  <= ovf_d;
         end
      end
   end
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.overflow  = ovf_q;
   assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_adder_16bit_sync.sv
// tb_adder_16bit_sync: vector table, control sequences and random traffic against an integer reference model
module tb_adder_16bit_sync;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   adder_16bit_sync_if bus ();
   adder_16bit_sync dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [15:0] a, b;
      logic        cin;
      logic [15:0] s;
      logic        co, ov;
   } vec_t;
   vec_t tbl[9];
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask
   task automatic chk_out(input string name, input logic [15:0] s, input logic co, input logic ov, input logic v);
      chk({name, ".sum"}, {16'h0, bus.sum}, {16'h0, s});
      chk({name, ".cout"}, {31'h0, bus.cout}, {31'h0, co});
      chk({name, ".ovf"}, {31'h0, bus.overflow}, {31'h0, ov});
      chk({name, ".valid"}, {31'h0, bus.out_valid}, {31'h0, v});
   endtask
   function automatic void ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                   output logic [15:0] s, output logic co, output logic ov);
      int u, sv;
      u  = int'(a) + int'(b) + int'(cin);
      sv = int'($signed(a)) + int'($signed(b)) + int'(cin);
      s  = u[15:0];
      co = u[16];
      ov = (sv > 32767) || (sv < -32768);
`ifdef ADDER_16BIT_SAT_EN
      if (ov) s = (sv > 0) ? 16'h7FFF : 16'h8000;
`endif
   endfunction
   task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic cin);
      bus.in_valid = v;
      bus.a = a;
      bus.b = b;
      bus.cin = cin;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [15:0] es, ra, rb;
      logic eco, eov, rc;
      tbl[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b0};
`ifdef ADDER_16BIT_SAT_EN
      tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
      tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
      tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
      tbl[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
      tbl[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      tbl[8] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
      step();
      step();
      chk_out("reset", 16'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
         step();
         chk_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].co, tbl[i].ov, 1'b1);
      end
      drive(1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
      step();
      chk_out("hold1", 16'h5556, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 16'h7FFF, 16'h7FFF, 1'b0);
      step();
      chk_out("hold2", 16'h5556, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 16'h8000, 16'hFFFF, 1'b0);
      step();
      ref_add(16'h8000, 16'hFFFF, 1'b0, es, eco, eov);
      chk_out("pre_rst", es, eco, eov, 1'b1);
      rst = 1'b1;
      drive(1'b1, 16'h4000, 16'h4000, 1'b0);
      step();
      chk_out("mid_rst", 16'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b1, 16'h4000, 16'h4000, 1'b0);
      step();
      ref_add(16'h4000, 16'h4000, 1'b0, es, eco, eov);
      chk_out("resume", es, eco, eov, 1'b1);
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom);
         drive(1'b1, ra, rb, rc);
         step();
         ref_add(ra, rb, rc, es, eco, eov);
         chk_out($sformatf("rnd%0d", i), es, eco, eov, 1'b1);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
